// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
// The current owner is kept while i_hold is high. Otherwise the search starts just after the last owner.
module wb_rr_arbiter #(
  parameter int num_requests = 2,
  localparam int IW = (num_requests > 1) ? $clog2(num_requests) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [num_requests-1:0] i_request,
  input  logic                    i_hold,
  output logic [num_requests-1:0] o_grant,
  output logic [IW-1:0]           o_sel
);

  logic [num_requests-1:0] r_grant;
  logic [IW-1:0]           r_last;
  logic [num_requests-1:0] w_next_grant;
  logic [IW-1:0]           w_next_idx;
  logic                    w_found;

  // Candidate offset i maps to index j when last+i equals j, either directly or wrapped by one lap.
  always_comb begin
    w_next_grant = '0;
    w_next_idx   = r_last;
    w_found      = 1'b0;
    for (int i = 1; i <= num_requests; i++) begin
      for (int j = 0; j < num_requests; j++) begin
        if (!w_found && i_request[j] &&
            ((int'(r_last) + i == j) || (int'(r_last) + i == j + num_requests))) begin
          w_found         = 1'b1;
          w_next_grant[j] = 1'b1;
          w_next_idx      = IW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_last  <= IW'(num_requests - 1);
    end else if (!i_hold) begin
      r_grant <= w_next_grant;
      if (w_found) begin
        r_last <= w_next_idx;
      end
    end
  end

  assign o_grant = r_grant;
  assign o_sel   = r_last;

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone B3 N-to-1 arbiter. The grant lasts for the owner's whole cyc.
// Slave-bound signals are muxed from the owner. Responses are routed back only to the owner.
module wb_arbiter #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 2,
  localparam int SW = dw / 8,
  localparam int IW = (num_masters > 1) ? $clog2(num_masters) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [num_masters*aw-1:0] wbm_adr_i,
  input  logic [num_masters*dw-1:0] wbm_dat_i,
  input  logic [num_masters*SW-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [num_masters*3-1:0]  wbm_cti_i,
  input  logic [num_masters*2-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0] wbm_dat_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [SW-1:0]             wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i
);

  logic [num_masters-1:0] w_grant;
  logic [IW-1:0]          w_sel;
  logic                   w_any;
  logic                   w_hold;
  logic [aw-1:0]          w_adr [num_masters];
  logic [dw-1:0]          w_dat [num_masters];
  logic [SW-1:0]          w_bsel [num_masters];
  logic [2:0]             w_cti [num_masters];
  logic [1:0]             w_bte [num_masters];

  assign w_hold = |(w_grant & wbm_cyc_i);
  assign w_any  = |w_grant;

  wb_rr_arbiter #(
    .num_requests(num_masters)
  ) u_rr (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .i_request(wbm_cyc_i),
    .i_hold   (w_hold),
    .o_grant  (w_grant),
    .o_sel    (w_sel)
  );

  for (genvar gi = 0; gi < num_masters; gi++) begin : g_split
    assign w_adr[gi]  = wbm_adr_i[gi*aw +: aw];
    assign w_dat[gi]  = wbm_dat_i[gi*dw +: dw];
    assign w_bsel[gi] = wbm_sel_i[gi*SW +: SW];
    assign w_cti[gi]  = wbm_cti_i[gi*3 +: 3];
    assign w_bte[gi]  = wbm_bte_i[gi*2 +: 2];
    assign wbm_dat_o[gi*dw +: dw] = wbs_dat_i;
  end

  // The last-owner index doubles as the mux select, but only while a grant is active.
  assign wbs_adr_o = w_any ? w_adr[w_sel]  : '0;
  assign wbs_dat_o = w_any ? w_dat[w_sel]  : '0;
  assign wbs_sel_o = w_any ? w_bsel[w_sel] : '0;
  assign wbs_cti_o = w_any ? w_cti[w_sel]  : '0;
  assign wbs_bte_o = w_any ? w_bte[w_sel]  : '0;
  assign wbs_we_o  = w_any & wbm_we_i[w_sel];
  assign wbs_cyc_o = w_any & wbm_cyc_i[w_sel];
  assign wbs_stb_o = w_any & wbm_stb_i[w_sel];

  assign wbm_ack_o = {num_masters{wbs_ack_i}} & w_grant;
  assign wbm_err_o = {num_masters{wbs_err_i}} & w_grant;
  assign wbm_rty_o = {num_masters{wbs_rty_i}} & w_grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with five masters.
// Covers reset, round-robin order, burst hold, fairness, error routing and asynchronous reset.
module tb_wb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_err_o;
  logic [N-1:0]    wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o;
  logic            wbs_cyc_o;
  logic            wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i;
  logic            wbs_err_i;
  logic            wbs_rty_i;

  int n_checks = 0;
  int n_pass   = 0;
  int fair_seq [4] = '{0, 4, 0, 4};

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arbiter #(
    .dw(DW), .aw(AW), .num_masters(N)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i),
    .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i),
    .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i),
    .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] adr_of(input int k);
    return 32'(256 * (k + 1));
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  task automatic set_m(input int k, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    wbm_cyc_i[k]           = cyc;
    wbm_stb_i[k]           = cyc;
    wbm_adr_i[k*AW +: AW]  = adr;
    wbm_dat_i[k*DW +: DW]  = dat_of(k);
    wbm_sel_i[k*SW +: SW]  = 4'(k + 1);
    wbm_we_i[k]            = (k % 2) == 1;
    wbm_cti_i[k*3 +: 3]    = cti;
    wbm_bte_i[k*2 +: 2]    = 2'b00;
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  initial begin
    wb_rst_i  = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

    repeat (3) @(negedge wb_clk_i);
    check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    check("rst_ack", 32'(wbm_ack_o), 32'd0);
    check("rst_adr", wbs_adr_o, 32'd0);
    wb_rst_i = 1'b1;
    step(); step();
    check("idle_cyc", 32'(wbs_cyc_o), 32'd0);
    check("idle_ack", 32'(wbm_ack_o), 32'd0);
    check("idle_adr", wbs_adr_o, 32'd0);

    // All masters request together; expect order 0..4 with a bubble between owners.
    for (int k = 0; k < N; k++) set_m(k, 1'b1, adr_of(k), 3'b000);
    #1 check("all_req_same_cycle", 32'(wbs_cyc_o), 32'd0);
    for (int k = 0; k < N; k++) begin
      step();
      check("rr_cyc", 32'(wbs_cyc_o), 32'd1);
      check("rr_adr", wbs_adr_o, adr_of(k));
      check("rr_dat", wbs_dat_o, dat_of(k));
      check("rr_sel", 32'(wbs_sel_o), 32'(k + 1));
      check("rr_we", 32'(wbs_we_o), 32'(k % 2));
      wbs_ack_i = 1'b1;
      #1 check("rr_ack", 32'(wbm_ack_o), 32'(1 << k));
      $display("txn rr: master %0d owns bus, adr %h", k, wbs_adr_o);
      step();
      wbs_ack_i = 1'b0;
      set_m(k, 1'b0, 32'd0, 3'b000);
      #1 check("rr_bubble", 32'(wbs_cyc_o), 32'd0);
    end

    // Single read by master 2.
    step();
    set_m(2, 1'b1, 32'h1000, 3'b000);
    #1 check("m2_not_yet", 32'(wbs_cyc_o), 32'd0);
    step();
    check("m2_cyc", 32'(wbs_cyc_o), 32'd1);
    check("m2_adr", wbs_adr_o, 32'h1000);
    check("m2_we", 32'(wbs_we_o), 32'd0);
    wbs_dat_i = 32'hDEAD_BEEF;
    wbs_ack_i = 1'b1;
    #1 check("m2_ack", 32'(wbm_ack_o), 32'b00100);
    check("m2_rdata", wbm_dat_o[2*DW +: DW], 32'hDEAD_BEEF);
    $display("txn read: master 2 adr 1000 data %h", wbm_dat_o[2*DW +: DW]);
    step();
    wbs_ack_i = 1'b0;
    set_m(2, 1'b0, 32'd0, 3'b000);
    #1 check("m2_release", 32'(wbs_cyc_o), 32'd0);

    // Master 1 runs a 4-beat burst while master 3 waits.
    step();
    set_m(1, 1'b1, 32'h2000, 3'b010);
    step();
    set_m(3, 1'b1, 32'h3000, 3'b000);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 32'h2000 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      #1 check("burst_adr", wbs_adr_o, 32'h2000 + 32'(4 * b));
      check("burst_cti", 32'(wbs_cti_o), (b == 3) ? 32'd7 : 32'd2);
      check("burst_ack", 32'(wbm_ack_o), 32'b00010);
      $display("txn burst: beat %0d adr %h", b, wbs_adr_o);
      step();
    end
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 32'd0, 3'b000);
    #1 check("burst_release", 32'(wbs_cyc_o), 32'd0);
    step();
    check("m3_after_burst_cyc", 32'(wbs_cyc_o), 32'd1);
    check("m3_after_burst_adr", wbs_adr_o, 32'h3000);
    $display("txn burst: master 3 granted after burst");
    set_m(3, 1'b0, 32'd0, 3'b000);
    step();

    // Masters 0 and 4 keep re-requesting; ownership must alternate.
    set_m(0, 1'b1, adr_of(0), 3'b000);
    step();
    set_m(4, 1'b1, adr_of(4), 3'b000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) set_m(fair_seq[i-1], 1'b1, adr_of(fair_seq[i-1]), 3'b000);
      check("fair_adr", wbs_adr_o, adr_of(fair_seq[i]));
      wbs_ack_i = 1'b1;
      #1 check("fair_ack", 32'(wbm_ack_o), 32'(1 << fair_seq[i]));
      $display("txn fair: master %0d owns bus", fair_seq[i]);
      step();
      wbs_ack_i = 1'b0;
      set_m(fair_seq[i], 1'b0, 32'd0, 3'b000);
      #1 check("fair_bubble", 32'(wbs_cyc_o), 32'd0);
      step();
    end
    set_m(0, 1'b0, 32'd0, 3'b000);
    step();

    // Error routing to master 3, then asynchronous reset mid-cycle.
    set_m(3, 1'b1, 32'h3300, 3'b000);
    step();
    check("err_adr", wbs_adr_o, 32'h3300);
    wbs_err_i = 1'b1;
    #1 check("err_vec", 32'(wbm_err_o), 32'b01000);
    check("err_no_ack", 32'(wbm_ack_o), 32'd0);
    check("err_no_rty", 32'(wbm_rty_o), 32'd0);
    $display("txn err: master 3 err vector %b", wbm_err_o);
    wbs_err_i = 1'b0;
    #1 check("pre_rst_cyc", 32'(wbs_cyc_o), 32'd1);
    wb_rst_i = 1'b0;
    #1 check("async_rst_cyc", 32'(wbs_cyc_o), 32'd0);
    check("async_rst_adr", wbs_adr_o, 32'd0);
    step();
    check("rst_hold_cyc", 32'(wbs_cyc_o), 32'd0);
    set_m(0, 1'b1, adr_of(0), 3'b000);
    wb_rst_i = 1'b1;
    step();
    check("restart_adr", wbs_adr_o, adr_of(0));
    wbs_ack_i = 1'b1;
    #1 check("restart_ack", 32'(wbm_ack_o), 32'b00001);
    $display("txn reset: master %0d owns bus after reset", 0);
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 32'd0, 3'b000);
    set_m(3, 1'b0, 32'd0, 3'b000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
